// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry, named register indices and the $sp reset value.
package cpu_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NREGS     = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  localparam logic [DATA_W-1:0] SP_INIT_DEF = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/regfile_rd_port.sv
// One combinational register-file read port: 32:1 select, zero-force for index 0 and,
// with REGFILE_WR_BYPASS_EN defined, same-cycle write-to-read bypass.
module regfile_rd_port #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned NREGS  = cpu_pkg::NREGS
) (
  input  logic [NREGS-1:0][DATA_W-1:0]   regs_i,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  raddr_i,
`ifdef REGFILE_WR_BYPASS_EN
  input  logic                           we_i,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0]              wdata_i,
`endif
  output logic [DATA_W-1:0]              rdata_o
);
  import cpu_pkg::*;

  localparam logic [REG_IDX_W-1:0] IDX_ZERO = REG_IDX_W'(REG_ZERO);

  // Index 0 always reads zero, even if the bypass would otherwise match it.
  always_comb begin
    rdata_o = regs_i[raddr_i];
    if (raddr_i == IDX_ZERO) begin
      rdata_o = '0;
    end
`ifdef REGFILE_WR_BYPASS_EN
    if (we_i && (waddr_i != IDX_ZERO) && (raddr_i == waddr_i)) begin
      rdata_o = wdata_i;
    end
`endif
  end

endmodule : regfile_rd_port

// File: rtl/regfile_2r1w.sv
// 32 x DATA_W register file, one synchronous write port and two combinational read ports.
// REGFILE_WR_BYPASS_EN selects same-cycle write-to-read bypass on both read ports.
module regfile_2r1w #(
  parameter int unsigned       DATA_W  = cpu_pkg::DATA_W,
  parameter int unsigned       NREGS   = cpu_pkg::NREGS,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(cpu_pkg::SP_INIT_DEF)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [cpu_pkg::REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [cpu_pkg::REG_IDX_W-1:0] raddr1,
  input  logic [cpu_pkg::REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]             rdata1,
  output logic [DATA_W-1:0]             rdata2
);
  import cpu_pkg::*;

  localparam logic [REG_IDX_W-1:0] IDX_ZERO = REG_IDX_W'(REG_ZERO);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;

  // Write port; entry 0 is held at zero so it reduces to a constant.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (we && (waddr != IDX_ZERO)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Synchronous reset takes priority over a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        regs_q[k] <= (k == REG_SP) ? SP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rd_port1 (
    .regs_i  (regs_q),
    .raddr_i (raddr1),
`ifdef REGFILE_WR_BYPASS_EN
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
`endif
    .rdata_o (rdata1)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rd_port2 (
    .regs_i  (regs_q),
    .raddr_i (raddr2),
`ifdef REGFILE_WR_BYPASS_EN
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
`endif
    .rdata_o (rdata2)
  );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; follows REGFILE_WR_BYPASS_EN for hazard expectations.
module tb_regfile_2r1w;

  localparam logic [31:0] SP = 32'h0000_3FFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [32];

  regfile_2r1w #(
    .DATA_W  (32),
    .NREGS   (32),
    .SP_INIT (SP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    if (a != 5'd0) model[a] = d;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

    // Reset state sweep on both ports
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) model[k] = (k == 29) ? SP : 32'h0;
    for (int k = 0; k < 32; k++) begin
      raddr1 = 5'(k); raddr2 = 5'(31 - k);
      #1;
      check("rst_p1", k, rdata1, (k == 29) ? SP : 32'h0);
      check("rst_p2", 31 - k, rdata2, ((31 - k) == 29) ? SP : 32'h0);
    end

    // Write every register, then read all indices on both ports
    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'hA5A5_0000 + 32'(k));
    for (int k = 0; k < 32; k++) begin
      raddr1 = 5'(k); raddr2 = 5'(k);
      #1;
      check("wr_p1", k, rdata1, (k == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(k));
      check("wr_p2", k, rdata2, (k == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(k));
    end

    // Zero register ignores writes, same cycle and after
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("zero_same", 0, rdata1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("zero_next_p1", 0, rdata1, 32'h0);
    check("zero_next_p2", 0, rdata2, 32'h0);

    // Same-cycle write/read hazard on register 5
    write_reg(5'd5, 32'h1111_1111);
    we = 1'b1; waddr = 5'd5; wdata = 32'h2222_2222; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    check("haz_same_p1", 5, rdata1, 32'h2222_2222);
    check("haz_same_p2", 5, rdata2, 32'h2222_2222);
`else
    check("haz_same_p1", 5, rdata1, 32'h1111_1111);
    check("haz_same_p2", 5, rdata2, 32'h1111_1111);
`endif
    tick();
    model[5] = 32'h2222_2222;
    we = 1'b0;
    #1;
    check("haz_next_p1", 5, rdata1, 32'h2222_2222);

    // Write-disable: reg 3 set to 3, then a we=0 cycle must change nothing
    write_reg(5'd3, 32'h0000_0003);
    we = 1'b0; waddr = 5'd3; wdata = 32'hCAFE_F00D; raddr1 = 5'd3;
    tick();
    check("wdis_r3", 3, rdata1, 32'h0000_0003);
    for (int k = 0; k < 32; k++) begin
      raddr2 = 5'(k);
      #1;
      check("wdis_all", k, rdata2, model[k]);
    end

    // Reset asserted together with a write aborts the write
    write_reg(5'd10, 32'hDEAD_BEEF);
    raddr2 = 5'd10;
    #1;
    check("pre_rst_r10", 10, rdata2, 32'hDEAD_BEEF);
    rst_n = 1'b0; we = 1'b1; waddr = 5'd10; wdata = 32'h1234_5678;
    tick();
    rst_n = 1'b1; we = 1'b0; raddr1 = 5'd29; raddr2 = 5'd10;
    #1;
    check("mid_rst_r10", 10, rdata2, 32'h0);
    check("mid_rst_sp", 29, rdata1, SP);
    raddr1 = 5'd5;
    #1;
    check("mid_rst_r5", 5, rdata1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_2r1w
